// File: rtl/uart_tx_scheduler_if.sv
// Requester / UART-TX side bundle of the shared transmitter scheduler.
// The slave modport is the scheduler; the master modport is the environment.
interface uart_tx_scheduler_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    localparam int GW = $clog2(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    ack;
    logic               tx_start;
    logic [DW-1:0]      tx_data;
    logic               tx_done;
    logic               busy;
    logic [GW-1:0]      gnt_id;
    logic               timeout_err;

    modport master (
        output req, req_data, tx_done,
        input  ack, tx_start, tx_data, busy, gnt_id, timeout_err
    );

    modport slave (
        input  req, req_data, tx_done,
        output ack, tx_start, tx_data, busy, gnt_id, timeout_err
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART transmitter between NREQ byte producers,
// one byte per grant, with a watchdog that aborts a frame if tx_done never comes.
module uart_tx_scheduler #(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_scheduler_if.slave bus
);
    localparam int          GW = $clog2(NREQ);
    localparam int          TW = $clog2(TIMEOUT);
    localparam int unsigned N  = NREQ;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_DONE_OK = 3'd3;
    localparam logic [2:0] S_DONE_TO = 3'd4;

    logic [2:0]      state;
    logic [GW-1:0]   last_gnt;
    logic [GW-1:0]   gnt_r;
    logic [DW-1:0]   data_r;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_nx;

    logic [GW-1:0]   sel;
    logic            sel_vld;
    logic [DW-1:0]   data_sel;
    logic [NREQ-1:0] ack_c;

    // Scan last_gnt+1, +2, ... with wrap; the first requester found wins.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        sel     = '0;
        sel_vld = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = 32'(last_gnt) + k;
            if (idx >= N) idx = idx - N;
            if (!sel_vld && bus.req[GW'(idx)]) begin
                sel_vld = 1'b1;
                sel     = GW'(idx);
            end
        end
    end

    always_comb begin
        data_sel = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (GW'(i) == sel) data_sel = bus.req_data[i*DW +: DW];
        end
    end

    assign timer_nx = timer + TW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            last_gnt <= GW'(NREQ - 1);
            gnt_r    <= '0;
            data_r   <= '0;
            timer    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sel_vld) begin
                        gnt_r  <= sel;
                        data_r <= data_sel;
                        state  <= S_START;
                    end
                end
                S_START: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                // Abort compares the incremented count so WAIT lasts TIMEOUT-1 cycles.
                S_WAIT: begin
                    timer <= timer_nx;
                    if (bus.tx_done) state <= S_DONE_OK;
                    else if (timer_nx == TW'(TIMEOUT - 1)) state <= S_DONE_TO;
                end
                S_DONE_OK, S_DONE_TO: begin
                    last_gnt <= gnt_r;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ack_c = '0;
        if (state == S_DONE_OK) ack_c[gnt_r] = 1'b1;
    end

    assign bus.ack         = ack_c;
    assign bus.tx_start    = (state == S_START);
    assign bus.tx_data     = data_r;
    assign bus.busy        = (state != S_IDLE);
    assign bus.gnt_id      = gnt_r;
    assign bus.timeout_err = (state == S_DONE_TO);
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomised scoreboard bench for uart_tx_scheduler: per-requester byte queues,
// a TX-core responder that predicts each grant, and an output monitor.
module tb_uart_tx_scheduler;
    localparam int NREQ    = 4;
    localparam int DW      = 8;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    uart_tx_scheduler_if #(.NREQ(NREQ), .DW(DW)) bus ();

    uart_tx_scheduler #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Byte queues owned by the requester driver; main only posts loads/clears.
    logic [DW-1:0] bq [NREQ][$];
    int            ld_id   [2048];
    logic [DW-1:0] ld_byte [2048];
    int            ld_n     = 0;
    int            ld_rd    = 0;
    int            clr_gen  = 0;
    int            clr_seen = 0;

    // Scoreboard ring: pushed by the responder, popped by the monitor.
    bit ok_q  [256];
    int id_q  [256];
    int cyc_q [256];
    int scb_wr = 0;
    int scb_rd = 0;

    int gnt_log [2048];
    int gl_n = 0;

    bit auto_en     = 1'b1;
    int fix_d       = 0;
    int to_idx      = -1;
    bit force_stale = 1'b0;
    bit rand_to     = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic load(input int id, input logic [DW-1:0] b);
        ld_id[ld_n]   = id;
        ld_byte[ld_n] = b;
        ld_n++;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ack"},         bus.ack,         0);
        chk({tag, "_tx_start"},    bus.tx_start,    0);
        chk({tag, "_tx_data"},     bus.tx_data,     0);
        chk({tag, "_busy"},        bus.busy,        0);
        chk({tag, "_gnt_id"},      bus.gnt_id,      0);
        chk({tag, "_timeout_err"}, bus.timeout_err, 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset(tag);
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int t;
        int pend;
        t    = 0;
        pend = 1;
        while (pend != 0 && t < limit) begin
            @(negedge clk);
            t++;
            pend = (ld_n - ld_rd) + (clr_gen - clr_seen) + (scb_wr - scb_rd) + int'(bus.busy);
            for (int i = 0; i < NREQ; i++) pend += bq[i].size();
        end
        if (pend != 0) chk({tag, "_idle_timeout"}, pend, 0);
    endtask

    // Requester driver: pop on ack, apply posted clears/loads, present queue heads.
    initial begin
        bus.req      = '0;
        bus.req_data = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++)
                if (bus.ack[i] && bq[i].size() > 0) void'(bq[i].pop_front());
            if (clr_seen != clr_gen) begin
                for (int i = 0; i < NREQ; i++) bq[i].delete();
                clr_seen = clr_gen;
            end
            while (ld_rd < ld_n) begin
                bq[ld_id[ld_rd]].push_back(ld_byte[ld_rd]);
                ld_rd++;
            end
            for (int i = 0; i < NREQ; i++) begin
                bus.req[i]                = (bq[i].size() > 0);
                bus.req_data[i*DW +: DW]  = (bq[i].size() > 0) ? bq[i][0] : '0;
            end
        end
    end

    // TX-core responder and reference model: round robin over nonempty queues.
    initial begin
        int m_last;
        bit b2b;
        int prev_end;
        m_last      = NREQ - 1;
        b2b         = 1'b0;
        prev_end    = 0;
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_last = NREQ - 1;
                b2b    = 1'b0;
            end else if (auto_en && bus.tx_start) begin : frame
                int w, tot, d, s, n, e;
                bit to, stale, stable;
                logic [DW-1:0] ed;
                s   = cyc;
                w   = -1;
                tot = 0;
                for (int k = 1; k <= NREQ; k++) begin
                    int idx;
                    idx = (m_last + k) % NREQ;
                    if (w < 0 && bq[idx].size() > 0) w = idx;
                end
                for (int i = 0; i < NREQ; i++) tot += bq[i].size();
                if (w < 0) begin
                    chk("start_without_request", tot, 1);
                end else begin
                    ed = bq[w][0];
                    chk("gnt_id", bus.gnt_id, w);
                    chk("tx_data", bus.tx_data, ed);
                    if (b2b) chk("restart_gap", s - prev_end, 2);
                    to = (gl_n == to_idx) || (rand_to && $urandom_range(0, 5) == 0);
                    gnt_log[gl_n] = w;
                    gl_n++;
                    d     = (fix_d > 0) ? fix_d : int'($urandom_range(1, TIMEOUT - 1));
                    stale = force_stale || (fix_d == 0 && $urandom_range(0, 3) == 0);
                    e     = to ? s + TIMEOUT : s + d + 1;
                    ok_q[scb_wr % 256]  = !to;
                    id_q[scb_wr % 256]  = w;
                    cyc_q[scb_wr % 256] = e;
                    scb_wr++;
                    m_last   = w;
                    prev_end = e;
                    b2b      = (tot - (to ? 0 : 1)) > 0;
                    n        = to ? TIMEOUT - 1 : d;
                    stable   = 1'b1;
                    bus.tx_done = stale;
                    repeat (n) begin
                        @(negedge clk);
                        bus.tx_done = 1'b0;
                        if (bus.tx_data !== ed || bus.tx_start || bus.gnt_id != w) stable = 1'b0;
                    end
                    if (!to) begin
                        bus.tx_done = 1'b1;
                        @(negedge clk);
                        bus.tx_done = 1'b0;
                    end
                    chk("frame_stable", stable, 1);
                end
            end
        end
    end

    // Output monitor: every ack or timeout_err pulse must match the next expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && (bus.ack != '0 || bus.timeout_err)) begin
                if (scb_rd == scb_wr) begin
                    chk("unexpected_output", {bus.ack, bus.timeout_err}, 0);
                end else begin
                    int k;
                    k = scb_rd % 256;
                    chk("ack", bus.ack, ok_q[k] ? (64'd1 << id_q[k]) : 64'd0);
                    chk("timeout_err", bus.timeout_err, !ok_q[k]);
                    chk("out_cycle", cyc, cyc_q[k]);
                    scb_rd++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t;
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;

        // Single requester 2, tx_done 10 cycles after tx_start.
        base  = gl_n;
        fix_d = 10;
        load(2, 8'hA5);
        wait_idle("t1", 200);
        chk("t1_grants", gl_n - base, 1);
        chk("t1_grant_id", gnt_log[base], 2);
        chk("t1_busy", bus.busy, 0);
        chk("t1_gnt_id_hold", bus.gnt_id, 2);
        chk("t1_tx_data_hold", bus.tx_data, 8'hA5);

        // All four requesting, each re-presents once: order 0,1,2,3,0,1,2,3.
        do_reset("t2_reset");
        base  = gl_n;
        fix_d = 0;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++) load(i, 8'h10 + DW'(i));
        wait_idle("t2", 1000);
        chk("t2_grants", gl_n - base, 2 * NREQ);
        for (int j = 0; j < 2 * NREQ; j++) chk("t2_order", gnt_log[base + j], j % NREQ);

        // Forced timeout on first attempt, then retry succeeds.
        base   = gl_n;
        to_idx = gl_n;
        fix_d  = 4;
        load(0, 8'h3C);
        wait_idle("t3", 300);
        to_idx = -1;
        chk("t3_grants", gl_n - base, 2);
        chk("t3_first", gnt_log[base], 0);
        chk("t3_retry", gnt_log[base + 1], 0);

        // Stale tx_done during START must be ignored.
        base        = gl_n;
        force_stale = 1'b1;
        fix_d       = 5;
        load(1, 8'h4B);
        wait_idle("t4", 200);
        force_stale = 1'b0;
        chk("t4_grants", gl_n - base, 1);
        chk("t4_grant_id", gnt_log[base], 1);

        // Requester 1 raised and dropped during requester 0's frame; 0 also drops req.
        base  = gl_n;
        fix_d = 12;
        load(0, 8'h55);
        t = 0;
        while (gl_n == base && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (gl_n == base) chk("t6_start_timeout", gl_n - base, 1);
        repeat (2) @(negedge clk);
        load(1, 8'h66);
        repeat (3) @(negedge clk);
        clr_gen++;
        wait_idle("t6", 200);
        chk("t6_grants", gl_n - base, 1);
        chk("t6_grant_id", gnt_log[base], 0);

        // Reset mid-WAIT, then priority restarts from requester 0.
        auto_en = 1'b0;
        load(2, 8'h22);
        t = 0;
        while (!bus.tx_start && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.tx_start) chk("t5_start_timeout", bus.tx_start, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("t5_reset");
        clr_gen++;
        load(3, 8'h33);
        load(0, 8'h01);
        auto_en = 1'b1;
        repeat (2) @(negedge clk);
        base  = gl_n;
        fix_d = 3;
        rst   = 1'b0;
        wait_idle("t5", 300);
        chk("t5_grants", gl_n - base, 2);
        chk("t5_first", gnt_log[base], 0);
        chk("t5_second", gnt_log[base + 1], 3);

        // Random traffic with random delays, stale pulses and timeouts.
        fix_d   = 0;
        rand_to = 1'b1;
        for (int ep = 0; ep < 30; ep++) begin
            for (int i = 0; i < NREQ; i++) begin
                int nb;
                nb = $urandom_range(0, 3);
                for (int b = 0; b < nb; b++) load(i, DW'($urandom));
            end
            wait_idle("rand", 3000);
        end
        rand_to = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
